// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, datapath
// select values, FSM state enum and the decoded control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] ALUSRCB_REGB = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
    localparam logic [1:0] ALUSRCB_SIMM = 2'b10;
    localparam logic [1:0] ALUSRCB_ZIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ORIEX   = 4'd10,
        S_ITYPEWB = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    // fetch/pcwrite/branch are raw state flags; input gating happens in the top
    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       fetch;
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_state_dec.sv
// Pure combinational decode of the controller state into the datapath
// control word (Moore outputs only).
module mc_state_dec
    import mips_pkg::*;
(
    input  logic [3:0]        i_state,
    output logic [CTRL_W-1:0] o_ctrl
);

    state_t w_state;
    ctrl_t  w_ctrl;

    assign w_state = state_t'(i_state);
    assign o_ctrl  = w_ctrl;

    always_comb begin
        w_ctrl = '0;
        unique case (w_state)
            S_FETCH: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.fetch   = 1'b1;
                w_ctrl.alusrcb = ALUSRCB_FOUR;
                w_ctrl.aluop   = ALUOP_ADD;
                w_ctrl.pcsrc   = PCSRC_ALU;
            end
            S_DECODE: begin
                w_ctrl.alusrcb = ALUSRCB_SIMM;
                w_ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = ALUSRCB_SIMM;
                w_ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_req  = 1'b1;
                w_ctrl.memwrite = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            S_RTYPEEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = ALUSRCB_REGB;
                w_ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.regdst   = 1'b1;
            end
            S_BEQEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = ALUSRCB_REGB;
                w_ctrl.aluop   = ALUOP_SUB;
                w_ctrl.pcsrc   = PCSRC_ALUOUT;
                w_ctrl.branch  = 1'b1;
            end
            S_ADDIEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = ALUSRCB_SIMM;
                w_ctrl.aluop   = ALUOP_ADD;
            end
            S_ORIEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = ALUSRCB_ZIMM;
                w_ctrl.aluop   = ALUOP_OR;
            end
            S_ITYPEWB: begin
                w_ctrl.regwrite = 1'b1;
            end
            S_JEX: begin
                w_ctrl.pcsrc   = PCSRC_JUMP;
                w_ctrl.pcwrite = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: state register, next-state logic and the
// memory-wait watchdog; the control word comes from mc_state_dec.
module mc_controller
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       iord,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_wait_cnt;
    logic               r_illegal_op;
    logic               r_mem_timeout;
    logic               w_illegal;
    logic               w_timeout;
    logic [CTRL_W-1:0]  w_ctrl_bits;
    ctrl_t              w_ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // A waiting memory state stays put until mem_ready; the watchdog forces FETCH
    assign w_timeout = w_ctrl.mem_req && !mem_ready && (r_wait_cnt == CW'(WAIT_MAX));

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        unique case (r_state)
            S_FETCH:   if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_ORI:       w_next = S_ORIEX;
                    OP_J:         w_next = S_JEX;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:   if (mem_ready) w_next = S_FETCH;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX,
            S_ORIEX:   w_next = S_ITYPEWB;
            default:   w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_FETCH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_illegal_op  <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_illegal_op  <= w_illegal;
            r_mem_timeout <= w_timeout;
            if (w_ctrl.mem_req && !mem_ready && !w_timeout) r_wait_cnt <= r_wait_cnt + 1'b1;
            else                                             r_wait_cnt <= '0;
        end
    end

    mc_state_dec u_dec (
        .i_state (r_state),
        .o_ctrl  (w_ctrl_bits)
    );

    assign w_ctrl = ctrl_t'(w_ctrl_bits);

    always_comb begin
        mem_req     = w_ctrl.mem_req;
        memwrite    = w_ctrl.memwrite;
        irwrite     = w_ctrl.fetch & mem_ready;
        pcen        = (w_ctrl.fetch & mem_ready) | w_ctrl.pcwrite | (w_ctrl.branch & zero);
        iord        = w_ctrl.iord;
        regwrite    = w_ctrl.regwrite;
        regdst      = w_ctrl.regdst;
        memtoreg    = w_ctrl.memtoreg;
        alusrca     = w_ctrl.alusrca;
        alusrcb     = w_ctrl.alusrcb;
        pcsrc       = w_ctrl.pcsrc;
        aluop       = w_ctrl.aluop;
        illegal_op  = r_illegal_op;
        mem_timeout = r_mem_timeout;
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (WAIT_MAX=3): walks each instruction class
// and the reset, illegal-opcode and watchdog corner cases.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, memwrite, irwrite, pcen, iord, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal_op, mem_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mc_controller #(.WAIT_MAX(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .pcen        (pcen),
        .iord        (iord),
        .regwrite    (regwrite),
        .regdst      (regdst),
        .memtoreg    (memtoreg),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsrc       (pcsrc),
        .aluop       (aluop),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        op        = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) step();

        check("rst_mem_req", int'(mem_req), 1);
        check("rst_iord", int'(iord), 0);
        check("rst_alusrcb", int'(alusrcb), 1);
        check("rst_irwrite", int'(irwrite), 0);
        check("rst_regwrite", int'(regwrite), 0);
        check("rst_illegal", int'(illegal_op), 0);
        check("rst_timeout", int'(mem_timeout), 0);

        reset     = 1'b0;
        mem_ready = 1'b1;
        op        = 6'b100011;
        #1;
        check("lw_c1_irwrite", int'(irwrite), 1);
        check("lw_c1_pcen", int'(pcen), 1);
        check("lw_c1_regwrite", int'(regwrite), 0);
        step();
        check("lw_c2_alusrcb", int'(alusrcb), 2);
        check("lw_c2_irwrite", int'(irwrite), 0);
        check("lw_c2_mem_req", int'(mem_req), 0);
        step();
        check("lw_c3_alusrca", int'(alusrca), 1);
        check("lw_c3_alusrcb", int'(alusrcb), 2);
        step();
        check("lw_c4_mem_req", int'(mem_req), 1);
        check("lw_c4_iord", int'(iord), 1);
        check("lw_c4_regwrite", int'(regwrite), 0);
        check("lw_c4_memtoreg", int'(memtoreg), 0);
        step();
        check("lw_c5_regwrite", int'(regwrite), 1);
        check("lw_c5_memtoreg", int'(memtoreg), 1);
        check("lw_c5_regdst", int'(regdst), 0);
        step();
        check("lw_end_fetch", int'(alusrcb), 1);
        check("lw_end_regwrite", int'(regwrite), 0);

        op = 6'b000100; zero = 1'b1;
        step(); step();
        check("beq1_pcen", int'(pcen), 1);
        check("beq1_pcsrc", int'(pcsrc), 1);
        check("beq1_aluop", int'(aluop), 1);
        step();
        check("beq1_back_fetch", int'(mem_req), 1);
        zero = 1'b0;
        step(); step();
        check("beq0_pcen", int'(pcen), 0);
        check("beq0_pcsrc", int'(pcsrc), 1);
        step();
        check("beq0_back_fetch", int'(mem_req), 1);
        check("beq0_fetch_iord", int'(iord), 0);

        op = 6'b001101;
        step(); step();
        check("ori_aluop", int'(aluop), 3);
        check("ori_alusrcb", int'(alusrcb), 3);
        check("ori_alusrca", int'(alusrca), 1);
        step();
        check("ori_wb_regwrite", int'(regwrite), 1);
        check("ori_wb_regdst", int'(regdst), 0);
        check("ori_wb_memtoreg", int'(memtoreg), 0);
        step();

        op = 6'b000000;
        step(); step();
        check("rtype_aluop", int'(aluop), 2);
        check("rtype_alusrcb", int'(alusrcb), 0);
        #1 reset = 1'b1;
        #1;
        check("midrst_regwrite", int'(regwrite), 0);
        check("midrst_iord", int'(iord), 0);
        check("midrst_alusrcb", int'(alusrcb), 1);
        check("midrst_mem_req", int'(mem_req), 1);
        step();
        reset = 1'b0;
        step();
        check("after_rst_decode", int'(alusrcb), 2);
        check("after_rst_regwrite", int'(regwrite), 0);
        step(); step();
        check("rtype_wb_regwrite", int'(regwrite), 1);
        check("rtype_wb_regdst", int'(regdst), 1);
        step();

        op = 6'b111111;
        step();
        check("ill_decode_pulse_low", int'(illegal_op), 0);
        step();
        check("ill_pulse", int'(illegal_op), 1);
        check("ill_fetch", int'(mem_req), 1);
        check("ill_regwrite", int'(regwrite), 0);
        check("ill_memwrite", int'(memwrite), 0);
        op = 6'b000010;
        step();
        check("ill_pulse_gone", int'(illegal_op), 0);
        step();
        check("j_pcen", int'(pcen), 1);
        check("j_pcsrc", int'(pcsrc), 2);
        step();

        op = 6'b101011;
        step(); step(); step();
        check("sw_memwrite", int'(memwrite), 1);
        check("sw_iord", int'(iord), 1);
        check("sw_regwrite", int'(regwrite), 0);
        step();
        check("sw_end_memwrite", int'(memwrite), 0);
        check("sw_end_fetch", int'(alusrcb), 1);

        mem_ready = 1'b0;
        #1;
        check("wd_irwrite0", int'(irwrite), 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("wd_no_pulse", int'(mem_timeout), 0);
            check("wd_irwrite", int'(irwrite), 0);
        end
        step();
        check("wd_pulse", int'(mem_timeout), 1);
        check("wd_fetch", int'(mem_req), 1);
        check("wd_pulse_irwrite", int'(irwrite), 0);
        step();
        check("wd_pulse_end", int'(mem_timeout), 0);
        step(); step();
        op = 6'b001000;
        mem_ready = 1'b1;
        #1;
        check("wd_ready_irwrite", int'(irwrite), 1);
        step();
        check("wd_ready_wins", int'(mem_timeout), 0);
        check("wd_ready_decode", int'(alusrcb), 2);
        step();
        check("addi_alusrcb", int'(alusrcb), 2);
        check("addi_aluop", int'(aluop), 0);
        check("addi_alusrca", int'(alusrca), 1);
        step();
        check("addi_wb_regwrite", int'(regwrite), 1);
        check("addi_wb_regdst", int'(regdst), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
